// File: rtl/qs_deque_if.sv
// Command/response bundle for qs_deque: one command strobe in, registered
// pop result, occupancy and status out.
interface qs_deque_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        action;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output in_valid, in_data, action,
    input  out_valid, out_data, count, full, empty, err
  );

  modport slave (
    input  in_valid, in_data, action,
    output out_valid, out_data, count, full, empty, err
  );
endinterface

// File: rtl/qs_deque.sv
// Circular-buffer double-ended queue: push at tail, pop oldest (head) or
// newest (tail-1), flush. All outputs registered, one command per cycle.
module qs_deque #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input logic        clk,
  input logic        rst_n,
  qs_deque_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] ACT_PUSH      = 2'b00;
  localparam logic [1:0] ACT_POP_FRONT = 2'b01;
  localparam logic [1:0] ACT_POP_BACK  = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  head, tail, head_nxt, tail_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              full_q, empty_q;
  logic              out_valid_q, out_valid_nxt;
  logic [DATA_W-1:0] out_data_q, out_data_nxt;
  logic              err_q, err_nxt;
  logic              do_push;

  always_comb begin
    head_nxt      = head;
    tail_nxt      = tail;
    count_nxt     = count_q;
    out_valid_nxt = 1'b0;
    out_data_nxt  = '0;
    err_nxt       = 1'b0;
    do_push       = 1'b0;
    if (bus.in_valid) begin
      case (bus.action)
        ACT_PUSH: begin
          if (full_q) begin
            err_nxt = 1'b1;
          end else begin
            do_push   = 1'b1;
            tail_nxt  = tail + PTR_W'(1);
            count_nxt = count_q + CNT_W'(1);
          end
        end
        ACT_POP_FRONT: begin
          if (empty_q) begin
            err_nxt = 1'b1;
          end else begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = mem[head];
            head_nxt      = head + PTR_W'(1);
            count_nxt     = count_q - CNT_W'(1);
          end
        end
        ACT_POP_BACK: begin
          if (empty_q) begin
            err_nxt = 1'b1;
          end else begin
            // with one entry tail-1 == head, so both pop ends agree
            out_valid_nxt = 1'b1;
            out_data_nxt  = mem[tail - PTR_W'(1)];
            tail_nxt      = tail - PTR_W'(1);
            count_nxt     = count_q - CNT_W'(1);
          end
        end
        default: begin
          head_nxt  = '0;
          tail_nxt  = '0;
          count_nxt = '0;
        end
      endcase
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      count_q     <= count_nxt;
      full_q      <= (count_nxt == CNT_W'(DEPTH));
      empty_q     <= (count_nxt == '0);
      out_valid_q <= out_valid_nxt;
      out_data_q  <= out_data_nxt;
      err_q       <= err_nxt;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_qs_deque.sv
// Directed bench for qs_deque (DEPTH=4): stimulus queues expected pop/err
// events, a negedge monitor pops and compares whenever the DUT responds.
module tb_qs_deque;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POPF = 2'b01;
  localparam logic [1:0] POPB = 2'b10;
  localparam logic [1:0] FLSH = 2'b11;

  typedef struct {
    bit              is_err;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  qs_deque_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  qs_deque #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cmd(input logic [1:0] act, input logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.action   = act;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    cmd(PUSH, d);
  endtask

  task automatic pop(input logic [1:0] act, input logic [DATA_W-1:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
    cmd(act, '0);
  endtask

  task automatic bad(input logic [1:0] act);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    exp_q.push_back(e);
    cmd(act, 8'h5C);
  endtask

  task automatic status(input string tag, input int c, input int f, input int e);
    check({tag, ".count"}, int'(bus.count), c);
    check({tag, ".full"},  int'(bus.full),  f);
    check({tag, ".empty"}, int'(bus.empty), e);
  endtask

  // monitor: every out_valid or err cycle must match the next queued event
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid || bus.err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", {bus.out_valid, bus.err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp.err",       int'(bus.err),       int'(e.is_err));
        check("resp.out_valid", int'(bus.out_valid), int'(!e.is_err));
        check("resp.out_data",  int'(bus.out_data),  int'(e.data));
      end
    end else if (bus.out_data != '0) begin
      check("idle.out_data", int'(bus.out_data), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.action   = PUSH;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", int'(bus.out_valid), 0);
    check("rst.out_data",  int'(bus.out_data),  0);
    check("rst.err",       int'(bus.err),       0);
    status("rst", 0, 0, 1);
    rst_n = 1'b1;

    // pops from empty after reset
    bad(POPF);
    bad(POPB);
    status("empty_pops", 0, 0, 1);

    // FIFO order, back-to-back
    push(8'h11); push(8'h22); push(8'h33);
    status("fifo_fill", 3, 0, 0);
    pop(POPF, 8'h11); pop(POPF, 8'h22); pop(POPF, 8'h33);
    status("fifo_drain", 0, 0, 1);

    // LIFO order
    push(8'hA1); push(8'hA2); push(8'hA3);
    pop(POPB, 8'hA3); pop(POPB, 8'hA2); pop(POPB, 8'hA1);
    status("lifo_drain", 0, 0, 1);

    // full + overflow
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    status("full", 4, 1, 0);
    bad(PUSH);
    status("overflow", 4, 1, 0);
    pop(POPF, 8'h41);
    status("after_full_pop", 3, 0, 0);
    cmd(FLSH, '0);
    status("flush1", 0, 0, 1);

    // wrap and mixed ends
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    pop(POPF, 8'h01); pop(POPF, 8'h02); pop(POPF, 8'h03);
    push(8'h05); push(8'h06);
    status("wrap", 3, 0, 0);
    pop(POPB, 8'h06); pop(POPF, 8'h04); pop(POPF, 8'h05);
    status("wrap_drain", 0, 0, 1);

    // single entry via pop_back
    push(8'h5A);
    pop(POPB, 8'h5A);

    // flush then pop
    push(8'h10); push(8'h20);
    cmd(FLSH, '0);
    status("flush2", 0, 0, 1);
    cmd(FLSH, '0);
    status("flush_empty", 0, 0, 1);
    bad(POPF);

    // reset while a pop result is on the outputs
    push(8'h77); push(8'h88);
    bus.in_valid = 1'b1;
    bus.action   = POPF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", int'(bus.out_valid), 0);
    check("midrst.out_data",  int'(bus.out_data),  0);
    status("midrst", 0, 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad(POPF);
    bad(POPB);
    status("post_rst", 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
